mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (CPU/DMA) arbiter for a single memory port, one access in flight at a time.
// Optional DMA anti-starvation streak counter enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_be,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a master raises req with stable we/addr/wdata/be and holds them
  // until the single-cycle gnt pulse; gnt marks acceptance, rvalid marks read data.

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY out of range 1..4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT out of range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        owner;  // 1 = DMA owns the access in flight
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;
  logic [1:0]  wait_cnt;
  logic        starve;
  logic        pick_dma;
  logic        issue;
  logic        resp;
  logic        cpu_rd_busy;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] streak;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= 4'd0;
    end else if (state == ISSUE) begin
      if (owner) streak <= 4'd0;
      else if (dma_req && streak != 4'hF) streak <= streak + 4'd1;
    end
  end

  assign starve = (streak >= 4'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  assign pick_dma = dma_req && (!cpu_req || starve);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req || dma_req) state_nxt = ISSUE;
      ISSUE: begin
        if (l_we)                  state_nxt = IDLE;
        else if (MEM_LATENCY == 1) state_nxt = RESP;
        else                       state_nxt = WAIT;
      end
      WAIT:    if (wait_cnt == 2'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= 1'b0;
      l_we     <= 1'b0;
      l_addr   <= 32'd0;
      l_wdata  <= 32'd0;
      l_be     <= 4'd0;
      wait_cnt <= 2'd0;
    end else begin
      if (state == IDLE && (cpu_req || dma_req)) begin
        owner   <= pick_dma;
        l_we    <= pick_dma ? dma_we    : cpu_we;
        l_addr  <= pick_dma ? dma_addr  : cpu_addr;
        l_wdata <= pick_dma ? dma_wdata : cpu_wdata;
        l_be    <= pick_dma ? dma_be    : cpu_be;
      end
      // Loaded with LATENCY-1; WAIT leaves when the count reaches 1 so RESP
      // lands exactly MEM_LATENCY cycles after ISSUE.
      if (state == ISSUE)     wait_cnt <= 2'(MEM_LATENCY - 1);
      else if (state == WAIT) wait_cnt <= wait_cnt - 2'd1;
    end
  end

  assign issue = (state == ISSUE);
  assign resp  = (state == RESP);

  assign mem_en    = issue;
  assign mem_we    = issue && l_we;
  assign mem_addr  = issue ? l_addr  : 32'd0;
  assign mem_wdata = issue ? l_wdata : 32'd0;
  assign mem_be    = issue ? l_be    : 4'd0;

  assign cpu_gnt    = issue && !owner;
  assign dma_gnt    = issue && owner;
  assign cpu_rvalid = resp && !owner;
  assign dma_rvalid = resp && owner;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : 32'd0;

  assign cpu_rd_busy = (state == ISSUE || state == WAIT) && !owner && !l_we;
  assign cpu_stall   = reset && ((cpu_req && !cpu_gnt) || cpu_rd_busy);

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses MEM_LATENCY=1, instance b MEM_LATENCY=3.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic        a_cpu_req, a_cpu_we, a_cpu_gnt, a_cpu_rvalid, a_cpu_stall;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic [3:0]  a_cpu_be;
  logic        a_dma_req, a_dma_we, a_dma_gnt, a_dma_rvalid;
  logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
  logic [3:0]  a_dma_be;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;
  logic [1:0]  a_dbg_state;

  logic        b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_rvalid, b_cpu_stall;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic [3:0]  b_cpu_be;
  logic        b_dma_req, b_dma_we, b_dma_gnt, b_dma_rvalid;
  logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
  logic [3:0]  b_dma_be;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_dbg_state;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_be(a_cpu_be), .cpu_gnt(a_cpu_gnt),
    .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr),
    .dma_wdata(a_dma_wdata), .dma_be(a_dma_be), .dma_gnt(a_dma_gnt),
    .dma_rvalid(a_dma_rvalid), .dma_rdata(a_dma_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_rdata(a_mem_rdata),
    .dbg_state(a_dbg_state)
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_be(b_cpu_be), .cpu_gnt(b_cpu_gnt),
    .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr),
    .dma_wdata(b_dma_wdata), .dma_be(b_dma_be), .dma_gnt(b_dma_gnt),
    .dma_rvalid(b_dma_rvalid), .dma_rdata(b_dma_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
    .dbg_state(b_dbg_state)
  );

  task automatic idle_inputs();
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0; a_cpu_be = 0;
    a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0; a_dma_be = 0;
    a_mem_rdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0; b_cpu_be = 0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0; b_dma_be = 0;
    b_mem_rdata = 0;
  endtask

  // Drive point: just after the active edge that starts a cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h55; a_cpu_be = 4'hF;
    a_dma_req = 1; a_dma_we = 1; a_dma_addr = 32'h66; a_dma_be = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (a_cpu_gnt !== 1'b0 || a_dma_gnt !== 1'b0) begin bad++;
      $display("FAIL rst_gnt: got %b%b want 00", a_cpu_gnt, a_dma_gnt); end
    total++; if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0) begin bad++;
      $display("FAIL rst_mem_en: got %b%b want 00", a_mem_en, a_mem_we); end
    total++; if (a_mem_addr !== 32'd0 || a_mem_be !== 4'd0 || a_mem_wdata !== 32'd0) begin bad++;
      $display("FAIL rst_mem_bus: addr %h be %h wdata %h want 0", a_mem_addr, a_mem_be, a_mem_wdata); end
    total++; if (a_cpu_stall !== 1'b0) begin bad++;
      $display("FAIL rst_stall: got %b want 0", a_cpu_stall); end
    total++; if (a_cpu_rvalid !== 1'b0 || a_cpu_rdata !== 32'd0 || a_dma_rdata !== 32'd0) begin bad++;
      $display("FAIL rst_resp: rvalid %b rdata %h/%h want 0", a_cpu_rvalid, a_cpu_rdata, a_dma_rdata); end
    total++; if (a_dbg_state !== 2'd0 || b_dbg_state !== 2'd0) begin bad++;
      $display("FAIL rst_state: got %0d/%0d want 0", a_dbg_state, b_dbg_state); end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    next_cycle();
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h100; a_cpu_be = 4'hF;
    a_mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (a_cpu_gnt !== 1'b0 || a_cpu_stall !== 1'b1) begin bad++;
      $display("FAIL rd_c0: gnt %b stall %b want 0 1", a_cpu_gnt, a_cpu_stall); end
    next_cycle();
    @(negedge clk);
    total++; if (a_cpu_gnt !== 1'b1 || a_mem_en !== 1'b1 || a_mem_we !== 1'b0) begin bad++;
      $display("FAIL rd_c1_gnt: gnt %b en %b we %b want 1 1 0", a_cpu_gnt, a_mem_en, a_mem_we); end
    total++; if (a_mem_addr !== 32'h100 || a_cpu_stall !== 1'b1) begin bad++;
      $display("FAIL rd_c1_addr: addr %h stall %b want 100 1", a_mem_addr, a_cpu_stall); end
    a_cpu_req = 0;
    next_cycle();
    @(negedge clk);
    total++; if (a_cpu_rvalid !== 1'b1 || a_cpu_rdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL rd_c2_data: rvalid %b rdata %h want 1 deadbeef", a_cpu_rvalid, a_cpu_rdata); end
    total++; if (a_cpu_stall !== 1'b0 || a_dma_rvalid !== 1'b0 || a_dma_rdata !== 32'd0) begin bad++;
      $display("FAIL rd_c2_side: stall %b dma_rvalid %b dma_rdata %h want 0 0 0", a_cpu_stall, a_dma_rvalid, a_dma_rdata); end
    next_cycle();
    @(negedge clk);
    total++; if (a_cpu_rvalid !== 1'b0 || a_cpu_rdata !== 32'd0 || a_dbg_state !== 2'd0) begin bad++;
      $display("FAIL rd_c3_idle: rvalid %b rdata %h state %0d want 0 0 0", a_cpu_rvalid, a_cpu_rdata, a_dbg_state); end
    a_mem_rdata = 0;
  endtask

  task automatic test_simul_write();
    next_cycle();
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h200; a_cpu_wdata = 32'h1111_2222; a_cpu_be = 4'hF;
    a_dma_req = 1; a_dma_we = 1; a_dma_addr = 32'h300; a_dma_wdata = 32'h3333_4444; a_dma_be = 4'hF;
    @(negedge clk);
    total++; if (a_cpu_stall !== 1'b1) begin bad++;
      $display("FAIL wr_c0_stall: got %b want 1", a_cpu_stall); end
    next_cycle();
    @(negedge clk);
    total++; if (a_cpu_gnt !== 1'b1 || a_dma_gnt !== 1'b0 || a_mem_we !== 1'b1) begin bad++;
      $display("FAIL wr_c1_gnt: cpu %b dma %b we %b want 1 0 1", a_cpu_gnt, a_dma_gnt, a_mem_we); end
    total++; if (a_mem_addr !== 32'h200 || a_mem_wdata !== 32'h1111_2222 || a_cpu_stall !== 1'b0) begin bad++;
      $display("FAIL wr_c1_bus: addr %h wdata %h stall %b want 200 11112222 0", a_mem_addr, a_mem_wdata, a_cpu_stall); end
    a_cpu_req = 0;
    next_cycle();
    @(negedge clk);
    total++; if (a_dma_gnt !== 1'b0 || a_mem_en !== 1'b0) begin bad++;
      $display("FAIL wr_c2_idle: dma_gnt %b en %b want 0 0", a_dma_gnt, a_mem_en); end
    next_cycle();
    @(negedge clk);
    total++; if (a_dma_gnt !== 1'b1 || a_cpu_gnt !== 1'b0 || a_mem_we !== 1'b1) begin bad++;
      $display("FAIL wr_c3_gnt: dma %b cpu %b we %b want 1 0 1", a_dma_gnt, a_cpu_gnt, a_mem_we); end
    total++; if (a_mem_addr !== 32'h300 || a_mem_wdata !== 32'h3333_4444) begin bad++;
      $display("FAIL wr_c3_bus: addr %h wdata %h want 300 33334444", a_mem_addr, a_mem_wdata); end
    a_dma_req = 0;
  endtask

  task automatic test_fairness();
    logic exp_dma [10];
    logic got_dma [10];
    int n;
    int cyc;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_dma[i] = (i % 5 == 4);
`else
      exp_dma[i] = 1'b0;
`endif
      got_dma[i] = 1'b0;
    end
    next_cycle();
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h210; a_cpu_be = 4'hF;
    a_dma_req = 1; a_dma_we = 1; a_dma_addr = 32'h310; a_dma_be = 4'hF;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 30) begin
      @(negedge clk);
      if (a_cpu_gnt === 1'b1 || a_dma_gnt === 1'b1) begin
        got_dma[n] = a_dma_gnt;
        n++;
      end
      cyc++;
    end
    a_cpu_req = 0;
    a_dma_req = 0;
    total++; if (n != 10) begin bad++;
      $display("FAIL fair_count: got %0d grants want 10 within 30 cycles", n); end
    for (int i = 0; i < 10; i++) begin
      total++; if (got_dma[i] !== exp_dma[i]) begin bad++;
        $display("FAIL fair_order[%0d]: dma_gnt %b want %b", i, got_dma[i], exp_dma[i]); end
    end
    next_cycle();
  endtask

  task automatic test_byte_write();
    next_cycle();
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 32'h404; a_cpu_wdata = 32'h00AB_0000; a_cpu_be = 4'b0100;
    @(negedge clk);
    total++; if (a_mem_en !== 1'b0 || a_mem_be !== 4'd0) begin bad++;
      $display("FAIL be_c0: en %b be %b want 0 0000", a_mem_en, a_mem_be); end
    next_cycle();
    @(negedge clk);
    total++; if (a_mem_be !== 4'b0100 || a_mem_addr !== 32'h404 || a_mem_wdata !== 32'h00AB_0000) begin bad++;
      $display("FAIL be_c1: be %b addr %h wdata %h want 0100 404 00ab0000", a_mem_be, a_mem_addr, a_mem_wdata); end
    a_cpu_req = 0;
    next_cycle();
    @(negedge clk);
    total++; if (a_mem_be !== 4'd0 || a_mem_addr !== 32'd0 || a_mem_en !== 1'b0) begin bad++;
      $display("FAIL be_c2: be %b addr %h en %b want 0000 0 0", a_mem_be, a_mem_addr, a_mem_en); end
  endtask

  task automatic test_latency3();
    next_cycle();
    b_dma_req = 1; b_dma_we = 0; b_dma_addr = 32'h500; b_dma_be = 4'hF;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    total++; if (b_dma_gnt !== 1'b1 || b_mem_addr !== 32'h500) begin bad++;
      $display("FAIL l3_c1_gnt: gnt %b addr %h want 1 500", b_dma_gnt, b_mem_addr); end
    b_dma_req = 0;
    next_cycle();
    b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 32'h600; b_cpu_wdata = 32'h6666_0000; b_cpu_be = 4'hF;
    @(negedge clk);
    total++; if (b_dma_rvalid !== 1'b0 || b_cpu_gnt !== 1'b0 || b_dbg_state !== 2'd2) begin bad++;
      $display("FAIL l3_c2: rvalid %b cpu_gnt %b state %0d want 0 0 2", b_dma_rvalid, b_cpu_gnt, b_dbg_state); end
    next_cycle();
    b_mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if (b_dma_rvalid !== 1'b0 || b_cpu_gnt !== 1'b0) begin bad++;
      $display("FAIL l3_c3: rvalid %b cpu_gnt %b want 0 0", b_dma_rvalid, b_cpu_gnt); end
    next_cycle();
    @(negedge clk);
    total++; if (b_dma_rvalid !== 1'b1 || b_dma_rdata !== 32'hCAFE_F00D) begin bad++;
      $display("FAIL l3_c4_data: rvalid %b rdata %h want 1 cafef00d", b_dma_rvalid, b_dma_rdata); end
    total++; if (b_cpu_gnt !== 1'b0 || b_cpu_rvalid !== 1'b0 || b_cpu_rdata !== 32'd0 || b_cpu_stall !== 1'b1) begin bad++;
      $display("FAIL l3_c4_cpu: gnt %b rvalid %b rdata %h stall %b want 0 0 0 1", b_cpu_gnt, b_cpu_rvalid, b_cpu_rdata, b_cpu_stall); end
    next_cycle();
    @(negedge clk);
    total++; if (b_cpu_gnt !== 1'b0 || b_dbg_state !== 2'd0) begin bad++;
      $display("FAIL l3_c5: cpu_gnt %b state %0d want 0 0", b_cpu_gnt, b_dbg_state); end
    next_cycle();
    @(negedge clk);
    total++; if (b_cpu_gnt !== 1'b1 || b_mem_addr !== 32'h600 || b_mem_we !== 1'b1) begin bad++;
      $display("FAIL l3_c6: gnt %b addr %h we %b want 1 600 1", b_cpu_gnt, b_mem_addr, b_mem_we); end
    b_cpu_req = 0;
    b_mem_rdata = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int pulses;
    next_cycle();
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h700; b_cpu_be = 4'hF;
    b_mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    b_cpu_req = 0;
    next_cycle();
    @(negedge clk);
    total++; if (b_dbg_state !== 2'd2) begin bad++;
      $display("FAIL rm_wait: state %0d want 2", b_dbg_state); end
    reset = 1'b0;
    #1;
    total++; if (b_dbg_state !== 2'd0 || b_mem_en !== 1'b0 || b_cpu_stall !== 1'b0) begin bad++;
      $display("FAIL rm_async: state %0d en %b stall %b want 0 0 0", b_dbg_state, b_mem_en, b_cpu_stall); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b1;
      if (b_cpu_rvalid === 1'b1 || b_cpu_gnt === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++;
      $display("FAIL rm_no_pulse: got %0d gnt/rvalid pulses want 0", pulses); end
    next_cycle();
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h704; b_cpu_be = 4'hF;
    b_mem_rdata = 32'h1234_5678;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    total++; if (b_cpu_gnt !== 1'b1 || b_mem_addr !== 32'h704) begin bad++;
      $display("FAIL rm_fresh_gnt: gnt %b addr %h want 1 704", b_cpu_gnt, b_mem_addr); end
    b_cpu_req = 0;
    repeat (2) begin
      next_cycle();
      @(negedge clk);
      total++; if (b_cpu_rvalid !== 1'b0 || b_cpu_stall !== 1'b1) begin bad++;
        $display("FAIL rm_fresh_wait: rvalid %b stall %b want 0 1", b_cpu_rvalid, b_cpu_stall); end
    end
    next_cycle();
    @(negedge clk);
    total++; if (b_cpu_rvalid !== 1'b1 || b_cpu_rdata !== 32'h1234_5678) begin bad++;
      $display("FAIL rm_fresh_data: rvalid %b rdata %h want 1 12345678", b_cpu_rvalid, b_cpu_rdata); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_simul_write();
    test_fairness();
    test_byte_write();
    test_latency3();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
